// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : Data-port responder for the core: word RAM, 64-bit cycle timer
//           (built only when DMEM_TIMER_EN is defined), serial byte FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder #(
   parameter int          DEPTH      = 16384,
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [3:0]  wmask,
   input  logic        wen,
   output logic [31:0] read_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        access_fault,
   output logic [31:0] fault_addr
);

   localparam int          AW          = $clog2(DEPTH);
   localparam int          PW          = $clog2(FIFO_DEPTH);
   localparam int          CW          = PW + 1;
   localparam logic [31:0] C_RAM_BYTES = 32'(4 * DEPTH);
   localparam logic [31:0] C_SER_DATA  = 32'hA000_03F8;
   localparam logic [31:0] C_SER_STAT  = 32'hA000_03FC;

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic [31:0]   ram_offset;
   logic [AW-1:0] ram_idx;
   logic          hit_ram;
   logic          hit_sdata;
   logic          hit_sstat;
   logic          hit_tlo;
   logic          hit_thi;
   logic          mapped;

   // Offset subtraction wraps below BASE_ADDR, so one compare covers both bounds.
   assign ram_offset = address - BASE_ADDR;
   assign hit_ram    = ram_offset < C_RAM_BYTES;
   assign ram_idx    = address[AW+1:2];
   assign hit_sdata  = address == C_SER_DATA;
   assign hit_sstat  = address == C_SER_STAT;
   assign mapped     = hit_ram | hit_tlo | hit_thi | hit_sdata | hit_sstat;

   // ------------------------------------------------------------------------
   // Word RAM (contents not reset)
   // ------------------------------------------------------------------------
   logic [31:0] ram_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wen && hit_ram) begin
         for (int l = 0; l < 4; l++) begin
            if (wmask[l]) begin
               ram_q[ram_idx][8*l +: 8] <= write_data[8*l +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Cycle timer
   // ------------------------------------------------------------------------
   logic [31:0] timer_lo;
   logic [31:0] timer_hi;

`ifdef DMEM_TIMER_EN
   localparam logic [31:0] C_TIMER_LO = 32'hA000_0048;
   localparam logic [31:0] C_TIMER_HI = 32'hA000_004C;

   logic [63:0] timer_q;
   logic [63:0] timer_d;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  m);
      logic [31:0] r;
      r = old_w;
      for (int l = 0; l < 4; l++) begin
         if (m[l]) r[8*l +: 8] = new_w[8*l +: 8];
      end
      return r;
   endfunction

   assign hit_tlo = address == C_TIMER_LO;
   assign hit_thi = address == C_TIMER_HI;

   // A software write replaces the increment for that cycle.
   always_comb begin
      timer_d = timer_q + 64'd1;
      if (wen && hit_tlo) begin
         timer_d = {timer_q[63:32], merge_bytes(timer_q[31:0], write_data, wmask)};
      end else if (wen && hit_thi) begin
         timer_d = {merge_bytes(timer_q[63:32], write_data, wmask), timer_q[31:0]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) timer_q <= '0;
      else       timer_q <= timer_d;
   end

   assign timer_lo = timer_q[31:0];
   assign timer_hi = timer_q[63:32];
`else
   assign hit_tlo  = 1'b0;
   assign hit_thi  = 1'b0;
   assign timer_lo = '0;
   assign timer_hi = '0;
`endif

   // ------------------------------------------------------------------------
   // Serial FIFO
   // ------------------------------------------------------------------------
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          full, empty, pop, push_req, push_ok;

   always_comb begin
      full       = count_q == CW'(FIFO_DEPTH);
      empty      = count_q == '0;
      pop        = !empty && tx_ready;
      push_req   = wen && hit_sdata && wmask[0];
      // A simultaneous pop frees the slot, so a push into a full FIFO survives.
      push_ok    = push_req && (!full || pop);
      wr_ptr_d   = wr_ptr_q + PW'(push_ok);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      count_d    = count_q + CW'(push_ok) - CW'(pop);
      overflow_d = overflow_q | (push_req && !push_ok);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_ptr_q] <= write_data[7:0];
   end

   assign tx_valid = !empty;
   assign tx_data  = fifo_q[rd_ptr_q];

   // ------------------------------------------------------------------------
   // Access fault capture
   // ------------------------------------------------------------------------
   logic        fault_q, fault_d;
   logic [31:0] fault_addr_q, fault_addr_d;

   always_comb begin
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      if (wen && (wmask != 4'h0) && !mapped && !fault_q) begin
         fault_d      = 1'b1;
         fault_addr_d = address;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   assign access_fault = fault_q;
   assign fault_addr   = fault_addr_q;

   // ------------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------------
   always_comb begin
      read_data = '0;
      if (hit_ram)        read_data = ram_q[ram_idx];
      else if (hit_tlo)   read_data = timer_lo;
      else if (hit_thi)   read_data = timer_hi;
      else if (hit_sstat) read_data = {full, empty, overflow_q, 21'b0, 8'(count_q)};
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed self-checking bench for dmem_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   localparam logic [31:0] C_SER_DATA = 32'hA000_03F8;
   localparam logic [31:0] C_SER_STAT = 32'hA000_03FC;
   localparam logic [31:0] C_TIMER_LO = 32'hA000_0048;
   localparam logic [31:0] C_TIMER_HI = 32'hA000_004C;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [3:0]  wmask = '0;
   logic        wen = 1'b0;
   logic [31:0] read_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        access_fault;
   logic [31:0] fault_addr;

   int checks   = 0;
   int failures = 0;

   dmem_responder dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .write_data   (write_data),
      .wmask        (wmask),
      .wen          (wen),
      .read_data    (read_data),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .access_fault (access_fault),
      .fault_addr   (fault_addr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      address    = a;
      write_data = d;
      wmask      = m;
      wen        = 1'b1;
      tick();
      wen        = 1'b0;
      wmask      = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      address = a;
      wen     = 1'b0;
      #1;
      chk(tag, read_data, exp);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      chk("rst_fault", {31'b0, access_fault}, 32'h0);
      chk("rst_fault_addr", fault_addr, 32'h0);
      rd(C_SER_STAT, 32'h4000_0000, "rst_stat");
      reset = 1'b0;
      tick();

      // RAM byte-lane merge and boundary word
      store(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
      store(32'h8000_0010, 32'h0000_5500, 4'b0010);
      rd(32'h8000_0010, 32'hDEAD_55EF, "ram_merge");
      rd(32'h8000_0013, 32'hDEAD_55EF, "ram_low_bits_ignored");
      store(32'h8000_FFFC, 32'h1234_5678, 4'hF);
      rd(32'h8000_FFFC, 32'h1234_5678, "ram_top_word");
      chk("ram_top_no_fault", {31'b0, access_fault}, 32'h0);

      // Serial push, status, drain
      tx_ready = 1'b0;
      store(C_SER_DATA, 32'h0000_0048, 4'h1);
      store(C_SER_DATA, 32'h0000_0069, 4'h1);
      store(C_SER_DATA, 32'h0000_0077, 4'h2);
      rd(C_SER_STAT, 32'h0000_0002, "stat_two");
      rd(C_SER_DATA, 32'h0000_0000, "sdata_reads_zero");
      chk("tx_valid_two", {31'b0, tx_valid}, 32'h1);
      chk("tx_head_H", {24'b0, tx_data}, 32'h48);
      store(C_SER_STAT, 32'hFFFF_FFFF, 4'hF);
      chk("stat_write_no_fault", {31'b0, access_fault}, 32'h0);
      rd(C_SER_STAT, 32'h0000_0002, "stat_write_ignored");
      tx_ready = 1'b1;
      #1;
      chk("pop_first_H", {24'b0, tx_data}, 32'h48);
      tick();
      chk("pop_second_i", {24'b0, tx_data}, 32'h69);
      tick();
      tx_ready = 1'b0;
      chk("drained_valid", {31'b0, tx_valid}, 32'h0);
      rd(C_SER_STAT, 32'h4000_0000, "drained_stat");

      // Overflow, then push-while-full with a concurrent pop
      for (int i = 0; i < 17; i++) begin
         store(C_SER_DATA, {24'h0, 8'(8'h10 + i)}, 4'h1);
      end
      rd(C_SER_STAT, 32'hA000_0010, "overflow_stat");
      tx_ready = 1'b1;
      store(C_SER_DATA, 32'h0000_0077, 4'h1);
      tx_ready = 1'b0;
      rd(C_SER_STAT, 32'hA000_0010, "full_push_pop_stat");
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_valid", {31'b0, tx_valid}, 32'h1);
         chk("drain_byte", {24'b0, tx_data}, (i < 15) ? 32'(8'h11 + i) : 32'h77);
         tick();
      end
      tx_ready = 1'b0;
      chk("drain_done_valid", {31'b0, tx_valid}, 32'h0);
      rd(C_SER_STAT, 32'h6000_0000, "drain_done_stat");

      // Access faults and asynchronous reset
      store(32'h1000_0000, 32'h1111_1111, 4'hF);
      store(32'h2000_0000, 32'h2222_2222, 4'hF);
      chk("fault_set", {31'b0, access_fault}, 32'h1);
      chk("fault_first_addr", fault_addr, 32'h1000_0000);
      rd(32'h3000_0000, 32'h0, "unmapped_read");
      tick();
      chk("load_no_change", fault_addr, 32'h1000_0000);
      store(C_SER_DATA, 32'h0000_0041, 4'h1);
      chk("pre_reset_valid", {31'b0, tx_valid}, 32'h1);
      reset = 1'b1;
      #1;
      chk("async_rst_fault", {31'b0, access_fault}, 32'h0);
      chk("async_rst_fault_addr", fault_addr, 32'h0);
      chk("async_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      tick();
      reset = 1'b0;
      store(32'h4000_0000, 32'hFFFF_FFFF, 4'h0);
      chk("zero_mask_no_fault", {31'b0, access_fault}, 32'h0);
      store(32'h8001_0000, 32'hFFFF_FFFF, 4'hF);
      chk("ram_end_fault", {31'b0, access_fault}, 32'h1);
      chk("ram_end_fault_addr", fault_addr, 32'h8001_0000);

      // Timer section starts from a fresh reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
`ifdef DMEM_TIMER_EN
      repeat (100) tick();
      rd(C_TIMER_LO, 32'd100, "timer_lo_100");
      rd(C_TIMER_HI, 32'd0, "timer_hi_0");
      store(C_TIMER_LO, 32'hFFFF_FFFE, 4'hF);
      tick();
      tick();
      rd(C_TIMER_HI, 32'd1, "timer_carry_hi");
      rd(C_TIMER_LO, 32'd0, "timer_carry_lo");
      chk("timer_write_no_fault", {31'b0, access_fault}, 32'h0);
`else
      store(C_TIMER_LO, 32'h1234_5678, 4'hF);
      chk("timer_off_fault", {31'b0, access_fault}, 32'h1);
      chk("timer_off_fault_addr", fault_addr, C_TIMER_LO);
      rd(C_TIMER_LO, 32'h0, "timer_off_lo_zero");
      rd(C_TIMER_HI, 32'h0, "timer_off_hi_zero");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
